lif_sequencer: RTL and testbench

- Controller that drives the 2-bit state and 8-bit input bus of one LIF neuron datapath.
- On a start command it loads beta, then threshold, then streams a fixed number of stimulus samples through the neuron's READ state.
- It stalls safely when the stimulus stream is empty, counts output spikes, and signals completion.
- It sits between the chip I/O or host logic and the neuron instance, which owns membrane/threshold/beta storage.

---
 rtl/lif_sequencer.sv | 120 ++++++++++++
 tb/tb_lif_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_sequencer.sv
// Run controller for one LIF neuron: loads beta, then threshold, then streams cfg_steps samples.
// Outputs decode the registered state in the same cycle; an empty stimulus stream stalls the run by re-writing beta.
module lif_sequencer #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_beta,
  input  logic [7:0]        cfg_thresh,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic              abort,
  input  logic [7:0]        stim_data,
  input  logic              stim_valid,
  output logic              stim_ready,
  output logic [1:0]        neuron_state,
  output logic [7:0]        neuron_in,
  input  logic              spike_in,
  output logic              busy,
  output logic              spike_evt,
  output logic [STEP_W-1:0] spike_count,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BETA,
    S_THRESH,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [7:0]        beta_q;
  logic [7:0]        thresh_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] step_q;
  logic              accept;
  logic              last_step;

  assign accept    = (state == S_RUN) && stim_valid;
  assign last_step = (step_q == steps_q - STEP_W'(1));

  always_comb begin
    neuron_state = 2'b00;
    neuron_in    = 8'd0;
    stim_ready   = 1'b0;
    case (state)
      S_BETA: begin
        neuron_state = 2'b01;
        neuron_in    = beta_q;
      end
      S_THRESH: begin
        neuron_state = 2'b10;
        neuron_in    = thresh_q;
      end
      S_RUN: begin
        if (stim_valid) begin
          neuron_state = 2'b11;
          neuron_in    = stim_data;
          stim_ready   = 1'b1;
        end else begin
          // Rewriting the same beta keeps the membrane frozen while starved.
          neuron_state = 2'b01;
          neuron_in    = beta_q;
        end
      end
      S_DONE: begin
        neuron_state = 2'b01;
        neuron_in    = beta_q;
      end
      default: begin
        neuron_state = 2'b00;
        neuron_in    = 8'd0;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign spike_evt = accept && spike_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      beta_q      <= 8'd0;
      thresh_q    <= 8'd0;
      steps_q     <= '0;
      step_q      <= '0;
      spike_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            beta_q      <= cfg_beta;
            thresh_q    <= cfg_thresh;
            steps_q     <= cfg_steps;
            step_q      <= '0;
            spike_count <= '0;
            state       <= S_BETA;
          end
        end
        S_BETA:   state <= S_THRESH;
        S_THRESH: state <= (steps_q == '0) ? S_DONE : S_RUN;
        S_RUN: begin
          if (accept) begin
            step_q <= step_q + STEP_W'(1);
            if (spike_in) spike_count <= spike_count + STEP_W'(1);
            if (last_step) state <= S_DONE;
          end
        end
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      // Abort overrides the transition, but a sample offered this cycle is still counted above.
      if (abort && state != S_IDLE) state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_lif_sequencer.sv
// Directed bench for lif_sequencer with a small shift-leak neuron model driving spike_in.
module tb_lif_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_beta;
  logic [7:0] cfg_thresh;
  logic [7:0] cfg_steps;
  logic       abort;
  logic [7:0] stim_data;
  logic       stim_valid;
  logic       stim_ready;
  logic [1:0] neuron_state;
  logic [7:0] neuron_in;
  logic       spike_in;
  logic       busy;
  logic       spike_evt;
  logic [7:0] spike_count;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  lif_sequencer #(.STEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_beta(cfg_beta), .cfg_thresh(cfg_thresh),
    .cfg_steps(cfg_steps), .abort(abort), .stim_data(stim_data), .stim_valid(stim_valid),
    .stim_ready(stim_ready), .neuron_state(neuron_state), .neuron_in(neuron_in),
    .spike_in(spike_in), .busy(busy), .spike_evt(spike_evt), .spike_count(spike_count),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_beta = 8'd0; cfg_thresh = 8'd0; cfg_steps = 8'd0;
    stim_data = 8'h5a; stim_valid = 1'b1; spike_in = 1'b1;
    #3;
    n_cmp++;
    if (neuron_state !== 2'b00 || neuron_in !== 8'd0 || stim_ready !== 1'b0 || busy !== 1'b0 ||
        spike_evt !== 1'b0 || done !== 1'b0 || spike_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got ns=%b in=%0d rdy=%b busy=%b evt=%b done=%b cnt=%0d want all zero",
               neuron_state, neuron_in, stim_ready, busy, spike_evt, done, spike_count);
    end
    tick();
    rst = 1'b0; stim_valid = 1'b0; spike_in = 1'b0;
    tick();
  endtask

  // Two configs: thresh 200 never fires, thresh 150 fires on samples 2 and 4.
  task automatic test_basic();
    logic [1:0] exp_ns [0:7];
    int mem, nxt, exp_cnt;
    logic spk, in_run;
    exp_ns = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    for (int k = 0; k < 2; k++) begin
      mem = 0; nxt = 0; exp_cnt = 0;
      start = 1'b1; cfg_beta = 8'd1; cfg_thresh = (k == 0) ? 8'd200 : 8'd150; cfg_steps = 8'd4;
      stim_valid = 1'b1; stim_data = 8'd100;
      for (int c = 0; c < 8; c++) begin
        tick();
        start = 1'b0;
        in_run = (c >= 2 && c <= 5);
        spk = 1'b1;
        if (in_run) begin
          nxt = mem - (mem >> 1) + 100;
          spk = (nxt >= int'(cfg_thresh));
        end
        spike_in = spk;
        #1;
        n_cmp++;
        if (neuron_state !== exp_ns[c]) begin
          n_bad++; $display("FAIL basic_state k=%0d c=%0d got %b want %b", k, c, neuron_state, exp_ns[c]);
        end
        n_cmp++;
        if (done !== (c == 6)) begin
          n_bad++; $display("FAIL basic_done k=%0d c=%0d got %b want %b", k, c, done, c == 6);
        end
        n_cmp++;
        if (stim_ready !== in_run || spike_evt !== (in_run && spk)) begin
          n_bad++; $display("FAIL basic_rdy_evt k=%0d c=%0d got rdy=%b evt=%b want rdy=%b evt=%b",
                            k, c, stim_ready, spike_evt, in_run, in_run && spk);
        end
        if (in_run) begin
          mem = spk ? 0 : nxt;
          if (spk) exp_cnt++;
        end
      end
      n_cmp++;
      if (spike_count !== 8'(exp_cnt) || busy !== 1'b0) begin
        n_bad++; $display("FAIL basic_count k=%0d got cnt=%0d busy=%b want cnt=%0d busy=0", k, spike_count, busy, exp_cnt);
      end
    end
    stim_valid = 1'b0; spike_in = 1'b0;
  endtask

  task automatic test_stall();
    logic       vld [0:8];
    logic [1:0] ens [0:8];
    logic [7:0] ein [0:8];
    vld = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ens = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00};
    ein = '{8'd2, 8'd255, 8'd12, 8'd2, 8'd2, 8'd15, 8'd16, 8'd2, 8'd0};
    start = 1'b1; cfg_beta = 8'd2; cfg_thresh = 8'd255; cfg_steps = 8'd3; spike_in = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick();
      start = 1'b0;
      stim_valid = vld[c];
      stim_data = 8'(10 + c);
      #1;
      n_cmp++;
      if (neuron_state !== ens[c] || neuron_in !== ein[c]) begin
        n_bad++; $display("FAIL stall_drive c=%0d got ns=%b in=%0d want ns=%b in=%0d", c, neuron_state, neuron_in, ens[c], ein[c]);
      end
      n_cmp++;
      if (stim_ready !== (vld[c] && c >= 2 && c <= 6) || done !== (c == 7)) begin
        n_bad++; $display("FAIL stall_rdy_done c=%0d got rdy=%b done=%b want rdy=%b done=%b",
                          c, stim_ready, done, vld[c] && c >= 2 && c <= 6, c == 7);
      end
    end
    stim_valid = 1'b0;
  endtask

  task automatic test_zero_steps();
    logic [1:0] ens [0:3];
    ens = '{2'b01, 2'b10, 2'b01, 2'b00};
    start = 1'b1; cfg_beta = 8'd4; cfg_thresh = 8'd9; cfg_steps = 8'd0;
    stim_valid = 1'b1; stim_data = 8'd33; spike_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
      #1;
      n_cmp++;
      if (neuron_state !== ens[c] || done !== (c == 2) || stim_ready !== 1'b0) begin
        n_bad++; $display("FAIL zero_seq c=%0d got ns=%b done=%b rdy=%b want ns=%b done=%b rdy=0",
                          c, neuron_state, done, stim_ready, ens[c], c == 2);
      end
    end
    n_cmp++;
    if (spike_count !== 8'd0) begin
      n_bad++; $display("FAIL zero_count got %0d want 0", spike_count);
    end
    stim_valid = 1'b0; spike_in = 1'b0;
  endtask

  // thresh 50, beta 1, samples of 100: both accepted samples fire.
  task automatic test_abort();
    start = 1'b1; cfg_beta = 8'd1; cfg_thresh = 8'd50; cfg_steps = 8'd5;
    stim_valid = 1'b1; stim_data = 8'd100; spike_in = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      start = 1'b0;
      spike_in = (c == 2 || c == 3);
      stim_valid = (c <= 3);
      abort = (c == 4);
      #1;
      if (c == 2 || c == 3) begin
        n_cmp++;
        if (spike_evt !== 1'b1 || neuron_state !== 2'b11) begin
          n_bad++; $display("FAIL abort_run c=%0d got evt=%b ns=%b want evt=1 ns=11", c, spike_evt, neuron_state);
        end
      end
      if (c >= 5) begin
        n_cmp++;
        if (busy !== 1'b0 || neuron_state !== 2'b00 || spike_count !== 8'd2) begin
          n_bad++; $display("FAIL abort_idle c=%0d got busy=%b ns=%b cnt=%0d want busy=0 ns=00 cnt=2",
                            c, busy, neuron_state, spike_count);
        end
      end
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++; $display("FAIL abort_nodone c=%0d got done=%b want 0", c, done);
      end
    end
    abort = 1'b0; stim_valid = 1'b0; spike_in = 1'b0;
  endtask

  task automatic test_start_ignored();
    start = 1'b1; cfg_beta = 8'd3; cfg_thresh = 8'd9; cfg_steps = 8'd2;
    stim_valid = 1'b1; stim_data = 8'd7; spike_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      start = (c == 0 || c == 3);
      cfg_beta = 8'd5; cfg_thresh = 8'd77; cfg_steps = 8'd7;
      #1;
      if (c == 0 || c == 1) begin
        n_cmp++;
        if (neuron_in !== ((c == 0) ? 8'd3 : 8'd9)) begin
          n_bad++; $display("FAIL ign_cfg c=%0d got in=%0d want %0d", c, neuron_in, (c == 0) ? 3 : 9);
        end
      end
      n_cmp++;
      if (done !== (c == 4) || busy !== (c <= 4)) begin
        n_bad++; $display("FAIL ign_done c=%0d got done=%b busy=%b want done=%b busy=%b", c, done, busy, c == 4, c <= 4);
      end
    end
    start = 1'b0; stim_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; cfg_beta = 8'd4; cfg_thresh = 8'd1; cfg_steps = 8'd5;
    stim_valid = 1'b1; stim_data = 8'd20; spike_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
      #1;
    end
    n_cmp++;
    if (spike_count !== 8'd1 || neuron_state !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre got cnt=%0d ns=%b want cnt=1 ns=11", spike_count, neuron_state);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || neuron_state !== 2'b00 || neuron_in !== 8'd0 || stim_ready !== 1'b0 ||
        spike_evt !== 1'b0 || spike_count !== 8'd0) begin
      n_bad++; $display("FAIL rst_async got busy=%b ns=%b in=%0d rdy=%b evt=%b cnt=%0d want all zero",
                        busy, neuron_state, neuron_in, stim_ready, spike_evt, spike_count);
    end
    #1 rst = 1'b0;
    stim_valid = 1'b0; spike_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_steps();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
